// File: rtl/ofdm_pkg.sv
// ofdm_pkg: OFDM constants, FSM state enum and I/Q sample type shared by the CP inserter and the receiver stages.
// Defining OFDM_CP_PINGPONG_EN selects a two-bank CP-inserter buffer.
package ofdm_pkg;
    localparam int WORD_LENGTH = 16;
    localparam int FFT_LEN = 64;
    localparam int CP_LEN = 16;
    localparam int SYM_LEN = 80;
    localparam int PTR_W = $clog2(FFT_LEN);
    localparam int CNT_W = $clog2(SYM_LEN);
`ifdef OFDM_CP_PINGPONG_EN
    localparam int NBANKS = 2;
`else
    localparam int NBANKS = 1;
`endif
    typedef enum logic [1:0] {FILL, CP, DATA} state_t;
    typedef struct packed {
        logic signed [WORD_LENGTH-1:0] re;
        logic signed [WORD_LENGTH-1:0] im;
    } sample_t;
endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// ofdm_cp_inserter_if: IFFT-side sample input and DAC-side CP16+data64 output of the CP inserter.
interface ofdm_cp_inserter_if;
    import ofdm_pkg::*;
    logic signed [WORD_LENGTH-1:0] in_real, in_imag, tx_real, tx_imag;
    logic in_vld, in_rdy, tx_vld, sym_start;
    modport master(output in_real, in_imag, in_vld, input in_rdy, tx_real, tx_imag, tx_vld, sym_start);
    modport slave(input in_real, in_imag, in_vld, output in_rdy, tx_real, tx_imag, tx_vld, sym_start);
endinterface

// File: rtl/ofdm_cp_buffer.sv
// ofdm_cp_buffer: BANKS x 64 I/Q sample store, one write port, one registered read port that outputs zero when not reading.
module ofdm_cp_buffer
    import ofdm_pkg::*;
#(
    parameter int BANKS = 1,
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [BW-1:0]    i_wbank,
    input  logic [PTR_W-1:0] i_waddr,
    input  sample_t          i_wdata,
    input  logic             i_re,
    input  logic [BW-1:0]    i_rbank,
    input  logic [PTR_W-1:0] i_raddr,
    output sample_t          o_rdata
);
    localparam int AW = $clog2(BANKS * FFT_LEN);
    sample_t r_mem [BANKS*FFT_LEN];
    sample_t r_rdata;
    logic [AW-1:0] w_wa, w_ra;
    assign w_wa = AW'({i_wbank, i_waddr});
    assign w_ra = AW'({i_rbank, i_raddr});
    always_ff @(posedge clk) begin
        if (i_we) r_mem[w_wa] <= i_wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else r_rdata <= i_re ? r_mem[w_ra] : '0;
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/ofdm_cp_inserter.sv
// ofdm_cp_inserter: buffers 64 IFFT samples and emits 80-sample symbols (last 16 as cyclic prefix, then all 64).
// OFDM_CP_PINGPONG_EN: two banks so filling one overlaps emission from the other.
module ofdm_cp_inserter
    import ofdm_pkg::*;
(
    input logic clk,
    input logic rst,
    ofdm_cp_inserter_if.slave bus
);
    state_t r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [PTR_W-1:0] r_wptr, w_raddr;
    logic r_vld, r_sym;
    logic w_wr, w_last_wr, w_rdy, w_start, w_next, w_end, w_wbank, w_rbank;
    sample_t w_wdata, w_rdata;

    assign w_wr = bus.in_vld && w_rdy;
    assign w_last_wr = w_wr && (&r_wptr);
    assign w_end = (r_state == DATA) && (r_cnt == CNT_W'(FFT_LEN - 1));

`ifdef OFDM_CP_PINGPONG_EN
    logic [1:0] r_pend, w_full;
    logic r_wb, r_rb;
    // w_full counts a bank completing this cycle so emission starts without an idle cycle
    assign w_full = r_pend | ({1'b0, w_last_wr} << r_wb);
    assign w_rdy = !r_pend[r_wb];
    assign w_start = w_full[r_rb];
    assign w_next = w_full[!r_rb];
    assign w_wbank = r_wb;
    assign w_rbank = r_rb;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_wb <= 1'b0;
            r_rb <= 1'b0;
        end else begin
            r_pend <= w_full & ~({1'b0, w_end} << r_rb);
            r_wb <= r_wb ^ w_last_wr;
            r_rb <= r_rb ^ w_end;
        end
    end
`else
    assign w_rdy = (r_state == FILL);
    assign w_start = w_last_wr;
    assign w_next = 1'b0;
    assign w_wbank = 1'b0;
    assign w_rbank = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx = r_cnt + 1'b1;
        case (r_state)
            FILL: begin
                w_cnt_nx = '0;
                if (w_start) w_state_nx = CP;
            end
            CP: if (r_cnt == CNT_W'(CP_LEN - 1)) begin
                w_state_nx = DATA;
                w_cnt_nx = '0;
            end
            DATA: if (w_end) begin
                w_state_nx = w_next ? CP : FILL;
                w_cnt_nx = '0;
            end
            default: begin
                w_state_nx = FILL;
                w_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_cnt <= '0;
            r_wptr <= '0;
            r_vld <= 1'b0;
            r_sym <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt <= w_cnt_nx;
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            r_vld <= (r_state != FILL);
            r_sym <= (r_state == CP) && (r_cnt == '0);
        end
    end

    assign w_raddr = (r_state == CP) ? PTR_W'(FFT_LEN - CP_LEN) + r_cnt[PTR_W-1:0] : r_cnt[PTR_W-1:0];
    assign w_wdata = {bus.in_real, bus.in_imag};

    ofdm_cp_buffer #(.BANKS(NBANKS)) u_buf (
        .clk(clk),
        .rst(rst),
        .i_we(w_wr),
        .i_wbank(w_wbank),
        .i_waddr(r_wptr),
        .i_wdata(w_wdata),
        .i_re(r_state != FILL),
        .i_rbank(w_rbank),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

    assign bus.in_rdy = w_rdy;
    assign bus.tx_real = w_rdata.re;
    assign bus.tx_imag = w_rdata.im;
    assign bus.tx_vld = r_vld;
    assign bus.sym_start = r_sym;
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// tb_ofdm_cp_inserter: table-driven symbol tests with a scoreboard queue of expected CP16+data64 outputs.
module tb_ofdm_cp_inserter;
    import ofdm_pkg::*;

    typedef struct {
        logic signed [WORD_LENGTH-1:0] re;
        logic signed [WORD_LENGTH-1:0] im;
        bit sof;
    } exp_t;

    typedef struct {
        string name;
        int pat;
        int thr;
        bit bp;
        int exp_lat;
        int exp_hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ofdm_cp_inserter_if bus();
    ofdm_cp_inserter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int run_len = 0;
    int exp_run = SYM_LEN;
    exp_t q[$];
    exp_t e;
    sample_t cur [FFT_LEN];
    vec_t vecs [6];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_vld) begin
                run_len++;
                if (q.size() == 0) chk("tx_extra", bus.tx_vld, 0);
                else begin
                    e = q.pop_front();
                    chk("tx_real", bus.tx_real, e.re);
                    chk("tx_imag", bus.tx_imag, e.im);
                    chk("sym_start", bus.sym_start, e.sof);
                end
            end else if (run_len != 0) begin
                chk("vld_run", run_len, exp_run);
                run_len = 0;
            end
        end
    end

    task automatic gen(input int pat);
        for (int n = 0; n < FFT_LEN; n++) begin
            if (pat == 0) begin
                cur[n].re = WORD_LENGTH'(n);
                cur[n].im = WORD_LENGTH'(-n);
            end else if (pat == 1) begin
                cur[n].re = (n % 2 == 0) ? 16'sh8000 : 16'sh7FFF;
                cur[n].im = (n % 2 == 0) ? 16'sh7FFF : 16'sh8000;
            end else begin
                cur[n].re = WORD_LENGTH'($urandom);
                cur[n].im = WORD_LENGTH'($urandom);
            end
        end
        for (int k = 0; k < SYM_LEN; k++) begin
            exp_t x;
            x.re = (k < CP_LEN) ? cur[FFT_LEN - CP_LEN + k].re : cur[k - CP_LEN].re;
            x.im = (k < CP_LEN) ? cur[FFT_LEN - CP_LEN + k].im : cur[k - CP_LEN].im;
            x.sof = (k == 0);
            q.push_back(x);
        end
    endtask

    task automatic feed(input int thr);
        int i = 0;
        int cyc = 0;
        while (i < FFT_LEN && cyc < 4000) begin
            bit hs;
            bus.in_vld = (thr == 1) ? (cyc % 2 == 0) : (thr == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_real = cur[i].re;
            bus.in_imag = cur[i].im;
            hs = bus.in_vld && bus.in_rdy;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) i++;
        end
        chk("feed_count", i, FFT_LEN);
    endtask

    task automatic post(input bit bp, input int exp_lat, input int exp_hold);
        int lat = -1;
        int n = 0;
        int hold = 0;
        while (n < 300) begin
            bus.in_vld = bp && !bus.in_rdy;
            bus.in_real = 16'sh7FFF;
            bus.in_imag = 16'sh7FFF;
            if (bus.in_vld) hold++;
            if (lat < 0 && bus.tx_vld) lat = n;
            if (lat >= 0 && !bus.tx_vld) break;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_vld = 1'b0;
        chk("latency", lat, exp_lat);
        chk("rdy_low_cycles", hold, exp_hold);
        chk("rdy_idle", bus.in_rdy, 1);
        chk("idle_real_zero", bus.tx_real, 0);
        chk("idle_imag_zero", bus.tx_imag, 0);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"ramp", 0, 0, 1'b0, 1, 0};
        vecs[1] = '{"throttled", 0, 1, 1'b0, 1, 0};
        vecs[2] = '{"extremes", 1, 0, 1'b0, 1, 0};
        vecs[3] = '{"random_gaps", 2, 2, 1'b0, 1, 0};
        vecs[4] = '{"backpressure", 2, 0, 1'b1, 1, 80};
        vecs[5] = '{"after_bp", 0, 0, 1'b0, 1, 0};
        bus.in_vld = 1'b0;
        bus.in_real = '0;
        bus.in_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_rdy", bus.in_rdy, 1);
        chk("rst_tx_vld", bus.tx_vld, 0);
        chk("rst_sym_start", bus.sym_start, 0);
        chk("rst_tx_real", bus.tx_real, 0);
        chk("rst_tx_imag", bus.tx_imag, 0);
`ifndef OFDM_CP_PINGPONG_EN
        foreach (vecs[v]) begin
            gen(vecs[v].pat);
            feed(vecs[v].thr);
            post(vecs[v].bp, vecs[v].exp_lat, vecs[v].exp_hold);
        end
        begin
            int seen = 0;
            int n = 0;
            gen(0);
            feed(0);
            bus.in_vld = 1'b0;
            while (n < 200) begin
                if (bus.tx_vld) seen++;
                if (seen == CP_LEN + 21) break;
                @(posedge clk);
                #1;
                n++;
            end
            chk("rst_reach_data20", seen, CP_LEN + 21);
            rst = 1'b1;
            @(posedge clk);
            #1;
            run_len = 0;
            q.delete();
            chk("midrst_tx_vld", bus.tx_vld, 0);
            chk("midrst_tx_real", bus.tx_real, 0);
            chk("midrst_in_rdy", bus.in_rdy, 1);
            chk("midrst_sym_start", bus.sym_start, 0);
            rst = 1'b0;
            gen(0);
            feed(0);
            post(1'b0, 1, 0);
        end
`else
        begin
            int n = 0;
            exp_run = 10 * SYM_LEN;
            for (int s = 0; s < 10; s++) begin
                gen(2);
                feed(0);
            end
            bus.in_vld = 1'b0;
            while ((bus.tx_vld || q.size() != 0) && n < 2000) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("pp_queue_empty", q.size(), 0);
            chk("pp_tx_vld_low", bus.tx_vld, 0);
            chk("pp_rdy_idle", bus.in_rdy, 1);
        end
`endif
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
